// File: rtl/pulse_synth_pkg.sv
// -----------------------------------------------------------------------------
// pulse_synth_pkg
// Shared types, constants and width helpers for the multi-channel pulse
// synthesiser. The board top reuses the default debounce and prescale
// constants so that simulation builds can override them in one place.
// -----------------------------------------------------------------------------
package pulse_synth_pkg;

  // Board defaults: 100000 stable cycles of debounce, 1000 cycles per tick.
  localparam int DEB_CNT_DEFAULT  = 100000;
  localparam int PRESCALE_DEFAULT = 1000;

  // Scale adjustment requested in one cycle.
  typedef enum logic [1:0] {
    ADJ_NONE,
    ADJ_INC,
    ADJ_DEC
  } adj_e;

  // Ceiling log2 that never returns less than 1, so a counter or index
  // always has at least one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the channel-select index.
  function automatic int sel_w(input int num_ch);
    return clog2_min1(num_ch);
  endfunction

  // Width of the summed level, which must hold 0..num_ch inclusive.
  function automatic int lvl_w(input int num_ch);
    return $clog2(num_ch + 1);
  endfunction

endpackage

// File: rtl/pulse_synth_if.sv
// -----------------------------------------------------------------------------
// pulse_synth_if
// Board-facing signal bundle of the pulse synthesiser.
//   Enable_SW  per-channel enable switches (raw, level-sensitive)
//   Bt_Plus    raw button, increment the selected channel's scale
//   Bt_Minus   raw button, decrement the selected channel's scale
//   Bt_Sel     raw button, advance the selected channel
//   Sel_Ch     currently selected channel
//   Sel_Scale  scale of the selected channel
//   Pulse      PWM-encoded sum of the enabled channels
// master: the board / stimulus side. slave: the synthesiser core.
// -----------------------------------------------------------------------------
interface pulse_synth_if
  import pulse_synth_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int SCALE_W = 6
);

  localparam int SEL_W = sel_w(NUM_CH);

  logic [NUM_CH-1:0]  Enable_SW;
  logic               Bt_Plus;
  logic               Bt_Minus;
  logic               Bt_Sel;
  logic [SEL_W-1:0]   Sel_Ch;
  logic [SCALE_W-1:0] Sel_Scale;
  logic               Pulse;

  modport master (
    output Enable_SW, Bt_Plus, Bt_Minus, Bt_Sel,
    input  Sel_Ch, Sel_Scale, Pulse
  );

  modport slave (
    input  Enable_SW, Bt_Plus, Bt_Minus, Bt_Sel,
    output Sel_Ch, Sel_Scale, Pulse
  );

endinterface

// File: rtl/pulse_synth_button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Two-flop synchroniser followed by a stability counter. The accepted level
// flips only after DEB_CNT consecutive synced samples disagree with it; any
// agreeing sample clears the counter. rise is a one-cycle strobe on the
// accepted 0->1 transition, so a held button yields exactly one event.
//   clk      system clock
//   rst      asynchronous active-high reset
//   btn_raw  asynchronous button input
//   rise     one-cycle press event
// -----------------------------------------------------------------------------
module button_debounce
  import pulse_synth_pkg::*;
#(
  parameter int DEB_CNT = DEB_CNT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic rise
);

  localparam int CNT_W = clog2_min1(DEB_CNT);

  logic [1:0]       sync_q, sync_d;   // [0] metastable stage, [1] synced
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;

  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    sync_d   = {sync_q[0], btn_raw};
    cnt_d    = '0;
    stable_d = stable_q;
    rise_d   = 1'b0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_W'(DEB_CNT - 1)) begin
        stable_d = sync_q[1];
        rise_d   = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/pulse_synth_core.sv
// -----------------------------------------------------------------------------
// pulse_synth_core
// Multi-channel tone synthesiser. Three debounced buttons select a channel and
// adjust its frequency scale; each channel runs a phase accumulator advanced
// on a prescaled clock-enable tick, and the enabled channels' square waves are
// summed and PWM-encoded onto a single Pulse pin. Everything runs on sysclk.
//   sysclk  system clock
//   reset   asynchronous active-high reset
//   io      pulse_synth_if.slave (Enable_SW, Bt_Plus, Bt_Minus, Bt_Sel in;
//           Sel_Ch, Sel_Scale, Pulse out)
// Build option: define PULSE_SYNTH_PHASE_RST_EN to hold a disabled channel's
// accumulator at phase 0, keeping channels enabled together phase-aligned.
// -----------------------------------------------------------------------------
module pulse_synth_core
  import pulse_synth_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int SCALE_W    = 6,
  parameter int SCALE_INIT = 1,
  parameter int ACC_W      = 16,
  parameter int PRESCALE   = PRESCALE_DEFAULT,
  parameter int DEB_CNT    = DEB_CNT_DEFAULT
) (
  input  logic         sysclk,
  input  logic         reset,
  pulse_synth_if.slave io
);

  localparam int SEL_W = sel_w(NUM_CH);
  localparam int LVL_W = lvl_w(NUM_CH);
  localparam int PRE_W = clog2_min1(PRESCALE);

  // ---------------------------------------------------------------- buttons
  logic plus_ev, minus_ev, sel_ev;

  button_debounce #(.DEB_CNT(DEB_CNT)) u_deb_plus (
    .clk(sysclk), .rst(reset), .btn_raw(io.Bt_Plus), .rise(plus_ev)
  );
  button_debounce #(.DEB_CNT(DEB_CNT)) u_deb_minus (
    .clk(sysclk), .rst(reset), .btn_raw(io.Bt_Minus), .rise(minus_ev)
  );
  button_debounce #(.DEB_CNT(DEB_CNT)) u_deb_sel (
    .clk(sysclk), .rst(reset), .btn_raw(io.Bt_Sel), .rise(sel_ev)
  );

  // ------------------------------------------------------------------ state
  logic [NUM_CH-1:0]  en_meta_q, en_sync_q;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic               tick_q, tick_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SCALE_W-1:0] scale_q [NUM_CH];
  logic [SCALE_W-1:0] scale_d [NUM_CH];
  logic [ACC_W-1:0]   acc_q   [NUM_CH];
  logic [ACC_W-1:0]   acc_d   [NUM_CH];
  logic [NUM_CH-1:0]  sq;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [SEL_W-1:0]   pwm_q, pwm_d;
  logic               pulse_q, pulse_d;
  logic [SCALE_W-1:0] sel_scale;
  adj_e               adj;

  // Prescaler: tick is registered so it coincides with the counter wrapping
  // to 0, first appearing PRESCALE cycles after reset release.
  always_comb begin
    pre_d  = pre_q + PRE_W'(1);
    tick_d = 1'b0;
    if (pre_q == PRE_W'(PRESCALE - 1)) begin
      pre_d  = '0;
      tick_d = 1'b1;
    end
  end

  // Control: plus and minus together cancel. The adjustment uses the old
  // selection, so a simultaneous select advances only after the update.
  always_comb begin
    adj = ADJ_NONE;
    if (plus_ev && !minus_ev) begin
      adj = ADJ_INC;
    end else if (minus_ev && !plus_ev) begin
      adj = ADJ_DEC;
    end

    scale_d = scale_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_q == SEL_W'(k)) begin
        case (adj)
          ADJ_INC: if (scale_q[k] != '1) scale_d[k] = scale_q[k] + SCALE_W'(1);
          ADJ_DEC: if (scale_q[k] != '0) scale_d[k] = scale_q[k] - SCALE_W'(1);
          default: ;
        endcase
      end
    end

    sel_d = sel_q;
    if (sel_ev) begin
      sel_d = (sel_q == SEL_W'(NUM_CH - 1)) ? '0 : sel_q + SEL_W'(1);
    end
  end

  always_comb begin
    sel_scale = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_q == SEL_W'(k)) sel_scale = scale_q[k];
    end
  end

  // Accumulators: the size cast zero-extends (or truncates) the scale, which
  // leaves the modulo-2^ACC_W sum unchanged either way.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
`ifdef PULSE_SYNTH_PHASE_RST_EN
    assign acc_d[k] = !en_sync_q[k] ? '0 :
                      tick_q        ? acc_q[k] + ACC_W'(scale_q[k]) : acc_q[k];
`else
    assign acc_d[k] = tick_q ? acc_q[k] + ACC_W'(scale_q[k]) : acc_q[k];
`endif
    assign sq[k] = acc_q[k][ACC_W-1];
  end

  // Level: number of enabled channels whose square wave is high.
  always_comb begin
    level_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      level_d = level_d + LVL_W'(sq[k] & en_sync_q[k]);
    end
  end

  // PWM: a free-running 0..NUM_CH-1 counter compared against the level, so
  // level 0 is constant low and level NUM_CH is constant high.
  always_comb begin
    pwm_d   = (pwm_q == SEL_W'(NUM_CH - 1)) ? '0 : pwm_q + SEL_W'(1);
    pulse_d = LVL_W'(pwm_q) < level_q;
  end

  // NOTE: the scale and accumulator arrays are a handful of flops, not a RAM,
  // so they are reset element by element like any other register.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      en_meta_q <= '0;
      en_sync_q <= '0;
      pre_q     <= '0;
      tick_q    <= 1'b0;
      sel_q     <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        scale_q[k] <= SCALE_W'(SCALE_INIT);
        acc_q[k]   <= '0;
      end
      level_q   <= '0;
      pwm_q     <= '0;
      pulse_q   <= 1'b0;
    end else begin
      en_meta_q <= io.Enable_SW;
      en_sync_q <= en_meta_q;
      pre_q     <= pre_d;
      tick_q    <= tick_d;
      sel_q     <= sel_d;
      scale_q   <= scale_d;
      acc_q     <= acc_d;
      level_q   <= level_d;
      pwm_q     <= pwm_d;
      pulse_q   <= pulse_d;
    end
  end

  assign io.Sel_Ch    = sel_q;
  assign io.Sel_Scale = sel_scale;
  assign io.Pulse     = pulse_q;

endmodule

// File: tb/tb_pulse_synth_core.sv
// -----------------------------------------------------------------------------
// tb_pulse_synth_core
// Directed bench for pulse_synth_core with NUM_CH=4, SCALE_W=6, SCALE_INIT=1,
// ACC_W=4, PRESCALE=2, DEB_CNT=4. Inputs change and outputs are sampled on
// the falling edge of sysclk.
// -----------------------------------------------------------------------------
module tb_pulse_synth_core;

  localparam int NUM_CH  = 4;
  localparam int SCALE_W = 6;
  localparam int ACC_W   = 4;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 sysclk = ~sysclk;

  pulse_synth_if #(.NUM_CH(NUM_CH), .SCALE_W(SCALE_W)) io ();

  pulse_synth_core #(
    .NUM_CH(NUM_CH), .SCALE_W(SCALE_W), .SCALE_INIT(1),
    .ACC_W(ACC_W), .PRESCALE(2), .DEB_CNT(4)
  ) dut (
    .sysclk(sysclk),
    .reset (reset),
    .io    (io)
  );

  // ------------------------------------------------------------ helpers
  task automatic apply_reset(input logic [NUM_CH-1:0] en);
    reset        = 1'b1;
    io.Enable_SW = en;
    io.Bt_Plus   = 1'b0;
    io.Bt_Minus  = 1'b0;
    io.Bt_Sel    = 1'b0;
    repeat (3) @(negedge sysclk);
    reset = 1'b0;
  endtask

  // Hold the given buttons for 8 cycles, then release for 8 cycles: long
  // enough for both the press and the release to debounce.
  task automatic press(input logic p, input logic m, input logic s);
    @(negedge sysclk);
    io.Bt_Plus  = p;
    io.Bt_Minus = m;
    io.Bt_Sel   = s;
    repeat (8) @(negedge sysclk);
    io.Bt_Plus  = 1'b0;
    io.Bt_Minus = 1'b0;
    io.Bt_Sel   = 1'b0;
    repeat (8) @(negedge sysclk);
  endtask

  task automatic wait_pulse(input logic val, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (io.Pulse === val) begin
        ok = 1'b1;
        break;
      end
      @(negedge sysclk);
    end
  endtask

  // ------------------------------------------------------------ scenarios
  task automatic test_reset;
    int ones;
    apply_reset('0);
    @(negedge sysclk);
    n_total++;
    if (io.Pulse !== 1'b0) $display("FAIL reset_pulse: got %b want 0", io.Pulse);
    else n_pass++;
    n_total++;
    if (io.Sel_Ch !== 2'd0) $display("FAIL reset_sel_ch: got %0d want 0", io.Sel_Ch);
    else n_pass++;
    n_total++;
    if (io.Sel_Scale !== 6'd1) $display("FAIL reset_sel_scale: got %0d want 1", io.Sel_Scale);
    else n_pass++;
    // Level 0 (all disabled) must keep Pulse low while accumulators run.
    ones = 0;
    repeat (40) begin
      @(negedge sysclk);
      if (io.Pulse !== 1'b0) ones++;
    end
    n_total++;
    if (ones != 0) $display("FAIL level0_const_low: got %0d high cycles want 0", ones);
    else n_pass++;
  endtask

  task automatic test_debounce;
    int changes;
    logic [SCALE_W-1:0] prev;
    logic [5:0] bounce;
    changes = 0;
    prev    = io.Sel_Scale;
    bounce  = 6'b000101;  // 1,0,1 over three cycles, then held high
    for (int i = 0; i < 3 + 20; i++) begin
      @(negedge sysclk);
      io.Bt_Plus = (i < 3) ? bounce[i] : 1'b1;
      if (io.Sel_Scale !== prev) changes++;
      prev = io.Sel_Scale;
    end
    io.Bt_Plus = 1'b0;
    repeat (10) begin
      @(negedge sysclk);
      if (io.Sel_Scale !== prev) changes++;
      prev = io.Sel_Scale;
    end
    n_total++;
    if (changes != 1) $display("FAIL debounce_one_event: got %0d events want 1", changes);
    else n_pass++;
    n_total++;
    if (io.Sel_Scale !== 6'd2) $display("FAIL debounce_scale: got %0d want 2", io.Sel_Scale);
    else n_pass++;
    // A 3-cycle glitch is shorter than DEB_CNT and must be ignored.
    @(negedge sysclk);
    io.Bt_Plus = 1'b1;
    repeat (3) @(negedge sysclk);
    io.Bt_Plus = 1'b0;
    repeat (12) @(negedge sysclk);
    n_total++;
    if (io.Sel_Scale !== 6'd2) $display("FAIL short_bounce: got %0d want 2", io.Sel_Scale);
    else n_pass++;
  endtask

  task automatic test_saturation;
    repeat (70) press(1'b1, 1'b0, 1'b0);
    n_total++;
    if (io.Sel_Scale !== 6'd63) $display("FAIL sat_high: got %0d want 63", io.Sel_Scale);
    else n_pass++;
    repeat (70) press(1'b0, 1'b1, 1'b0);
    n_total++;
    if (io.Sel_Scale !== 6'd0) $display("FAIL sat_low: got %0d want 0", io.Sel_Scale);
    else n_pass++;
    press(1'b1, 1'b0, 1'b0);
    n_total++;
    if (io.Sel_Scale !== 6'd1) $display("FAIL plus_from_zero: got %0d want 1", io.Sel_Scale);
    else n_pass++;
    press(1'b1, 1'b1, 1'b0);
    n_total++;
    if (io.Sel_Scale !== 6'd1) $display("FAIL plus_minus_cancel: got %0d want 1", io.Sel_Scale);
    else n_pass++;
  endtask

  task automatic test_select;
    logic [1:0] exp_ch [4];
    logic [5:0] exp_sc [4];
    exp_ch = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      press(1'b0, 1'b0, 1'b1);
      n_total++;
      if (io.Sel_Ch !== exp_ch[i])
        $display("FAIL sel_wrap[%0d]: got %0d want %0d", i, io.Sel_Ch, exp_ch[i]);
      else n_pass++;
    end
    press(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    n_total++;
    if (io.Sel_Scale !== 6'd2) $display("FAIL ch2_plus: got %0d want 2", io.Sel_Scale);
    else n_pass++;
    // Walk channels 3,0,1,2: only channel 2 was changed.
    exp_sc = '{6'd1, 6'd1, 6'd1, 6'd2};
    for (int i = 0; i < 4; i++) begin
      press(1'b0, 1'b0, 1'b1);
      n_total++;
      if (io.Sel_Scale !== exp_sc[i])
        $display("FAIL scale_walk[%0d]: got %0d want %0d", i, io.Sel_Scale, exp_sc[i]);
      else n_pass++;
    end
    // Plus with select: channel 2 becomes 3, selection moves to 3.
    press(1'b1, 1'b0, 1'b1);
    n_total++;
    if (io.Sel_Ch !== 2'd3 || io.Sel_Scale !== 6'd1)
      $display("FAIL sel_plus_same_cycle: got ch %0d scale %0d want ch 3 scale 1",
               io.Sel_Ch, io.Sel_Scale);
    else n_pass++;
    repeat (3) press(1'b0, 1'b0, 1'b1);
    n_total++;
    if (io.Sel_Scale !== 6'd3) $display("FAIL sel_plus_old_ch: got %0d want 3", io.Sel_Scale);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    bit ok;
    apply_reset('1);
    repeat (4) press(1'b1, 1'b0, 1'b0);
    n_total++;
    if (io.Sel_Scale !== 6'd5) $display("FAIL mid_setup_scale: got %0d want 5", io.Sel_Scale);
    else n_pass++;
    wait_pulse(1'b1, 100, ok);
    n_total++;
    if (!ok) $display("FAIL mid_pulse_seen: got timeout want Pulse=1");
    else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if (io.Sel_Scale !== 6'd1 || io.Pulse !== 1'b0 || io.Sel_Ch !== 2'd0)
      $display("FAIL mid_reset_async: got scale %0d pulse %b ch %0d want 1 0 0",
               io.Sel_Scale, io.Pulse, io.Sel_Ch);
    else n_pass++;
  endtask

  task automatic test_single_channel;
    bit   ok;
    logic prev;
    int   ones, toggles, first_fall;
    apply_reset(4'b0001);
    ok   = 1'b0;
    prev = dut.acc_q[0][ACC_W-1];
    for (int i = 0; i < 100; i++) begin
      @(negedge sysclk);
      if (dut.acc_q[0][ACC_W-1] === 1'b1 && prev === 1'b0) begin
        ok = 1'b1;
        break;
      end
      prev = dut.acc_q[0][ACC_W-1];
    end
    n_total++;
    if (!ok) $display("FAIL single_sq_rise: got timeout want rising sq");
    else n_pass++;
    ones = 0; toggles = 0; first_fall = -1;
    prev = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (io.Pulse === 1'b1) ones++;
      if (dut.acc_q[0][ACC_W-1] !== prev) begin
        toggles++;
        if (first_fall < 0) first_fall = i;
      end
      prev = dut.acc_q[0][ACC_W-1];
      @(negedge sysclk);
    end
    n_total++;
    if (first_fall != 16 || toggles != 3)
      $display("FAIL single_sq_period: got fall@%0d toggles %0d want fall@16 toggles 3",
               first_fall, toggles);
    else n_pass++;
    // Level 1 of 4: one high cycle per PWM period during each 16-cycle high half.
    n_total++;
    if (ones != 8) $display("FAIL single_pwm_duty: got %0d high cycles want 8", ones);
    else n_pass++;
  endtask

  task automatic test_all_enabled;
    bit ok;
    int run1, run0;
    apply_reset('1);
    wait_pulse(1'b1, 100, ok);
    run1 = 0;
    while (io.Pulse === 1'b1 && run1 < 40) begin
      run1++;
      @(negedge sysclk);
    end
    run0 = 0;
    while (io.Pulse === 1'b0 && run0 < 40) begin
      run0++;
      @(negedge sysclk);
    end
    n_total++;
    if (!ok || run1 != 16 || run0 != 16)
      $display("FAIL all_enabled_runs: got ok %0d high %0d low %0d want 1 16 16",
               ok, run1, run0);
    else n_pass++;
  endtask

  task automatic test_two_high;
    bit ok1, ok2, ok3;
    int bad;
    logic [7:0] pat;
    pat = 8'b0011_0011;  // sample i expects pat[i]: 1,1,0,0,1,1,0,0
    apply_reset(4'b0011);
    wait_pulse(1'b1, 100, ok1);
    @(negedge sysclk);
    wait_pulse(1'b0, 10, ok2);
    wait_pulse(1'b1, 10, ok3);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (io.Pulse !== pat[i]) bad++;
      @(negedge sysclk);
    end
    n_total++;
    if (!(ok1 && ok2 && ok3) || bad != 0)
      $display("FAIL two_high_pattern: got sync %0d%0d%0d errors %0d want 111 0",
               ok1, ok2, ok3, bad);
    else n_pass++;
  endtask

  task automatic test_phase_rst;
    logic [ACC_W-1:0] a, b;
    bit ok;
    apply_reset('1);
    repeat (10) @(negedge sysclk);
    io.Enable_SW[1] = 1'b0;
    repeat (4) @(negedge sysclk);
    a = dut.acc_q[1];
    repeat (16) @(negedge sysclk);
    b = dut.acc_q[1];
    io.Enable_SW[1] = 1'b1;
`ifdef PULSE_SYNTH_PHASE_RST_EN
    n_total++;
    if (a !== '0 || b !== '0)
      $display("FAIL phase_hold_zero: got %0d,%0d want 0,0", a, b);
    else n_pass++;
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge sysclk);
      if (dut.acc_q[1] !== '0) begin
        ok = 1'b1;
        break;
      end
    end
    n_total++;
    if (!ok || dut.acc_q[1] !== 4'd1)
      $display("FAIL phase_resume_zero: got %0d want 1", dut.acc_q[1]);
    else n_pass++;
`else
    n_total++;
    if (b !== 4'(a + 4'd8))
      $display("FAIL free_run_disabled: got %0d want %0d", b, 4'(a + 4'd8));
    else n_pass++;
    ok = 1'b1;
    repeat (4) @(negedge sysclk);
    n_total++;
    if (!ok || dut.acc_q[1] !== dut.acc_q[0])
      $display("FAIL free_run_resume: got %0d want %0d", dut.acc_q[1], dut.acc_q[0]);
    else n_pass++;
`endif
  endtask

  // ------------------------------------------------------------ sequence
  initial begin
    io.Enable_SW = '0;
    io.Bt_Plus   = 1'b0;
    io.Bt_Minus  = 1'b0;
    io.Bt_Sel    = 1'b0;
    test_reset();
    test_debounce();
    test_saturation();
    test_select();
    test_reset_mid();
    test_single_channel();
    test_all_enabled();
    test_two_high();
    test_phase_rst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
